board_uart_serializer: RTL

//   Downstream stage of the Life simulation core. It snapshots the packed board state and

---
 rtl/life_pkg.sv | 36 +++
 rtl/board_uart_serializer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/life_pkg.sv
// Shared constants and types for the Life board serializer.
//   ANSI/ASCII control bytes used in the terminal frame
//   default live/dead cell characters
//   ser_state_e : serializer FSM states
//   home_byte() : byte for each position of the cursor-home escape
package life_pkg;

  localparam logic [7:0] ANSI_ESC       = 8'h1B;
  localparam logic [7:0] ANSI_LBRACKET  = 8'h5B;
  localparam logic [7:0] ANSI_SEMI      = 8'h3B;
  localparam logic [7:0] ANSI_HOME_H    = 8'h48;
  localparam logic [7:0] ASCII_CR       = 8'h0D;
  localparam logic [7:0] ASCII_LF       = 8'h0A;
  localparam logic [7:0] ALIVE_CHAR_DEF = 8'h4F;
  localparam logic [7:0] DEAD_CHAR_DEF  = 8'h20;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HOME = 3'd1,
    CELL = 3'd2,
    CRLF = 3'd3,
    FIN  = 3'd4
  } ser_state_e;

  function automatic logic [7:0] home_byte(input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = ANSI_ESC;
      2'd1:    b = ANSI_LBRACKET;
      2'd2:    b = ANSI_SEMI;
      default: b = ANSI_HOME_H;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/board_uart_serializer.sv
// Snapshots the packed Life board on start and streams it as an ANSI terminal
// frame (optional cursor-home escape, then one text row per board row, rows
// separated by CR LF) over a valid/ready byte stream.
// Ports:
//   clk, reset          clock, async active-high reset
//   start               frame request, taken only while idle
//   board               packed board, bit y*WIDTH+x = cell (x,y)
//   busy / done         frame in progress / one-cycle completion pulse
//   tx_data, tx_valid   byte stream out (registered)
//   tx_ready            sink accepts the byte when tx_valid & tx_ready
//
// state | meaning
// IDLE  | waiting for start
// HOME  | presenting cursor-home byte hidx (0..3)
// CELL  | presenting cell (col,row) of the snapshot
// CRLF  | presenting CR (hidx 0) or LF (hidx 1) between rows
// FIN   | done pulse, back to IDLE
module board_uart_serializer
  import life_pkg::*;
#(
  parameter int         WIDTH      = 8,
  parameter int         HEIGHT     = 8,
  parameter logic [7:0] ALIVE_CHAR = ALIVE_CHAR_DEF,
  parameter logic [7:0] DEAD_CHAR  = DEAD_CHAR_DEF,
  parameter bit         SEND_HOME  = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [WIDTH*HEIGHT-1:0]   board,
  output logic                      busy,
  output logic                      done,
  output logic [7:0]                tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready
);

  localparam int CW    = $clog2(WIDTH) + 1;
  localparam int RW    = $clog2(HEIGHT) + 1;
  localparam int NCELL = WIDTH * HEIGHT;
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

  ser_state_e       state_q, state_d;
  logic [1:0]       hidx_q, hidx_d;
  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic [NCELL-1:0] snap_q, snap_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic             xfer;
  logic [$clog2(NCELL)-1:0] cell_idx;

  assign xfer = tx_valid_q & tx_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      hidx_q     <= '0;
      col_q      <= '0;
      row_q      <= '0;
      snap_q     <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hidx_q     <= hidx_d;
      col_q      <= col_d;
      row_q      <= row_d;
      snap_q     <= snap_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  // The _d position names the byte shown next cycle; the byte itself is
  // muxed from that position so tx_data is registered yet has no bubble.
  always_comb begin
    state_d = state_q;
    hidx_d  = hidx_q;
    col_d   = col_q;
    row_d   = row_q;
    snap_d  = snap_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SEND_HOME ? HOME : CELL;
          hidx_d  = '0;
          col_d   = '0;
          row_d   = '0;
          snap_d  = board;
        end
      end
      HOME: begin
        if (xfer) begin
          if (hidx_q == 2'd3) begin
            state_d = CELL;
            col_d   = '0;
          end else begin
            hidx_d = hidx_q + 2'd1;
          end
        end
      end
      CELL: begin
        if (xfer) begin
          if (col_q == COL_LAST) begin
            state_d = (row_q == ROW_LAST) ? FIN : CRLF;
            hidx_d  = '0;
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      CRLF: begin
        if (xfer) begin
          if (hidx_q[0]) begin
            state_d = CELL;
            row_d   = row_q + RW'(1);
            col_d   = '0;
          end else begin
            hidx_d = hidx_q + 2'd1;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Power-of-2 dimensions make row*WIDTH+col a plain concatenation.
    cell_idx = {row_d[RW-2:0], col_d[CW-2:0]};

    tx_data_d  = 8'h00;
    tx_valid_d = 1'b0;
    case (state_d)
      HOME: begin
        tx_data_d  = home_byte(hidx_d);
        tx_valid_d = 1'b1;
      end
      CELL: begin
        tx_data_d  = snap_d[cell_idx] ? ALIVE_CHAR : DEAD_CHAR;
        tx_valid_d = 1'b1;
      end
      CRLF: begin
        tx_data_d  = hidx_d[0] ? ASCII_LF : ASCII_CR;
        tx_valid_d = 1'b1;
      end
      default: begin
        tx_data_d  = 8'h00;
        tx_valid_d = 1'b0;
      end
    endcase
  end

  // busy already drops in FIN; a start seen then is still ignored because
  // only IDLE accepts it.
  always_comb begin
    busy     = (state_q != IDLE) && (state_q != FIN);
    done     = (state_q == FIN);
    tx_data  = tx_data_q;
    tx_valid = tx_valid_q;
  end

endmodule
